mul4_fitness_scorer: RTL and testbench

- Downstream consumer of the evolved bit-sliced 2x2 multiplier candidates (inputs a1,a0,b1,b0; outputs y3..y0; 16 test lanes per 16-bit word).
- Accepts a stream of operand/result beats and computes the golden 4-bit product per lane.
- Counts matching output bits and fully correct lanes across NUM_BATCHES beats, then reports a fitness score and pulses done.

---
 rtl/mul4_fitness_scorer.sv | 140 ++++++++++++++
 tb/tb_mul4_fitness_scorer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul4_fitness_scorer.sv
// Fitness scorer for evolved bit-sliced 2x2 multipliers: compares candidate product
// bit-planes against the golden product over NUM_BATCHES beats, 16 lanes per beat.
module mul4_fitness_scorer #(
  parameter int unsigned NUM_BATCHES = 4,
  parameter int unsigned ACC_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a1,
  input  logic [15:0]      a0,
  input  logic [15:0]      b1,
  input  logic [15:0]      b0,
  input  logic [15:0]      y3,
  input  logic [15:0]      y2,
  input  logic [15:0]      y1,
  input  logic [15:0]      y0,
  output logic [ACC_W-1:0] score,
  output logic [ACC_W-1:0] perfect_lanes,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(NUM_BATCHES + 1);
  localparam int unsigned SUM_W = ACC_W + 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s1_valid;
  logic [15:0]      r_m3, r_m2, r_m1, r_m0;
  logic [ACC_W-1:0] r_score, r_perf;
  logic             r_done;

  logic [15:0]      w_g3, w_g2, w_g1, w_g0;
  logic [15:0]      w_m3, w_m2, w_m1, w_m0;
  logic             w_ready, w_xfer, w_start_ok;
  logic [6:0]       w_bit_pop;
  logic [4:0]       w_perf_pop;
  logic [SUM_W-1:0] w_score_sum, w_perf_sum;
  logic [ACC_W-1:0] w_score_next, w_perf_next;

  assign w_g0 = a0 & b0;
  assign w_g1 = (a1 & b0) ^ (a0 & b1);
  assign w_g2 = (a1 & b1) & ~(a0 & b0);
  assign w_g3 = a1 & a0 & b1 & b0;

  assign w_m0 = ~(y0 ^ w_g0);
  assign w_m1 = ~(y1 ^ w_g1);
  assign w_m2 = ~(y2 ^ w_g2);
  assign w_m3 = ~(y3 ^ w_g3);

  // Ready comes from registered state only, never from in_valid.
  assign w_ready    = (r_state == S_ACCUM);
  assign w_xfer     = in_valid & w_ready;
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));

  always_comb begin
    w_bit_pop  = '0;
    w_perf_pop = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      w_bit_pop  = w_bit_pop + 7'(r_m0[i]) + 7'(r_m1[i]) + 7'(r_m2[i]) + 7'(r_m3[i]);
      w_perf_pop = w_perf_pop + 5'(r_m3[i] & r_m2[i] & r_m1[i] & r_m0[i]);
    end
  end

  // Sums are computed wide so any carry out of ACC_W bits saturates the result.
  always_comb begin
    w_score_sum  = SUM_W'(r_score) + SUM_W'(w_bit_pop);
    w_perf_sum   = SUM_W'(r_perf) + SUM_W'(w_perf_pop);
    w_score_next = (|w_score_sum[SUM_W-1:ACC_W]) ? '1 : w_score_sum[ACC_W-1:0];
    w_perf_next  = (|w_perf_sum[SUM_W-1:ACC_W]) ? '1 : w_perf_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_m3       <= '0;
      r_m2       <= '0;
      r_m1       <= '0;
      r_m0       <= '0;
      r_score    <= '0;
      r_perf     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_m3 <= w_m3;
        r_m2 <= w_m2;
        r_m1 <= w_m1;
        r_m0 <= w_m0;
      end
      if (r_s1_valid) begin
        r_score <= w_score_next;
        r_perf  <= w_perf_next;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state <= S_ACCUM;
            r_cnt   <= '0;
            r_score <= '0;
            r_perf  <= '0;
          end
        end
        S_ACCUM: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(NUM_BATCHES - 1)) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!r_s1_valid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = w_ready;
  assign busy          = (r_state == S_ACCUM) | (r_state == S_DRAIN);
  assign done          = r_done;
  assign score         = r_score;
  assign perfect_lanes = r_perf;

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Bench for mul4_fitness_scorer: directed and random evaluations against a lane-wise
// arithmetic reference model, plus a small-accumulator instance for saturation.
module tb_mul4_fitness_scorer;

  typedef struct packed {
    logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, start2, in_valid2;
  logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
  logic        in_ready, busy, done;
  logic [15:0] score, perfect_lanes;
  logic        in_ready2, busy2, done2;
  logic [7:0]  score2, perfect_lanes2;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_sc, m_pf, m_cnt, done_seen;
  logic        m_ready;
  beat_t       cur, base, good;

  always #5 clk = ~clk;

  mul4_fitness_scorer #(.NUM_BATCHES(4), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .score(score), .perfect_lanes(perfect_lanes), .busy(busy), .done(done)
  );

  mul4_fitness_scorer #(.NUM_BATCHES(8), .ACC_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .score(score2), .perfect_lanes(perfect_lanes2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp)) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: treat each lane as a pair of 2-bit integers and multiply them.
  function automatic void beat_score(input beat_t b, output int bits, output int perf);
    int av, bv, pv, yv, diff;
    bits = 0;
    perf = 0;
    for (int i = 0; i < 16; i++) begin
      av   = 2 * int'(b.a1[i]) + int'(b.a0[i]);
      bv   = 2 * int'(b.b1[i]) + int'(b.b0[i]);
      pv   = av * bv;
      yv   = 8 * int'(b.y3[i]) + 4 * int'(b.y2[i]) + 2 * int'(b.y1[i]) + int'(b.y0[i]);
      diff = $countones(pv ^ yv);
      bits += 4 - diff;
      if (diff == 0) perf++;
    end
  endfunction

  function automatic beat_t with_correct_y(input beat_t b);
    beat_t r;
    int    pv;
    r = b;
    for (int i = 0; i < 16; i++) begin
      pv = (2 * int'(b.a1[i]) + int'(b.a0[i])) * (2 * int'(b.b1[i]) + int'(b.b0[i]));
      r.y0[i] = pv[0];
      r.y1[i] = pv[1];
      r.y2[i] = pv[2];
      r.y3[i] = pv[3];
    end
    return r;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic start_eval();
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    m_sc      = 0;
    m_pf      = 0;
    m_cnt     = 0;
    m_ready   = 1'b1;
    done_seen = 0;
    chk("start_score", 32'(score), 0);
    chk("start_perf", 32'(perfect_lanes), 0);
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(in_ready), 1);
  endtask

  // One clock: a transfer lands in the score two edges later, so the score seen
  // after this edge holds every beat transferred on earlier edges.
  task automatic step(input logic v, input logic st);
    int   bits, perf, exp_sc, exp_pf;
    logic xfer;
    {a1, a0, b1, b0, y3, y2, y1, y0} = cur;
    in_valid = v;
    start    = st;
    xfer     = v && m_ready;
    exp_sc   = m_sc;
    exp_pf   = m_pf;
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    if (xfer) begin
      beat_score(cur, bits, perf);
      m_sc = sat(m_sc + bits, 65535);
      m_pf = sat(m_pf + perf, 65535);
      m_cnt++;
      if (m_cnt == 4) m_ready = 1'b0;
    end
    if (done === 1'b1) done_seen++;
    chk("score", 32'(score), exp_sc);
    chk("perfect", 32'(perfect_lanes), exp_pf);
    chk("in_ready", 32'(in_ready), int'(m_ready));
  endtask

  task automatic drain();
    step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    chk("done_pulses", 32'(done_seen), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_done", 32'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d2;
    int iter;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; start2 = 1'b0; in_valid2 = 1'b0;
    {a1, a0, b1, b0, y3, y2, y1, y0} = '0;
    m_ready = 1'b0; m_sc = 0; m_pf = 0; m_cnt = 0; done_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_score", 32'(score), 0);
    chk("rst_perf", 32'(perfect_lanes), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(in_ready), 0);
    rst_n = 1'b1;

    base = '{a1: 16'hCCCC, a0: 16'hAAAA, b1: 16'hFF00, b0: 16'hF0F0,
             y3: 16'h8000, y2: 16'h4C00, y1: 16'h6AC0, y0: 16'hA0A0};

    // Fully correct candidate over all 16 operand combinations.
    start_eval();
    cur = base;
    repeat (4) step(1'b1, 1'b0);
    drain();
    chk("exh_score", 32'(score), 256);
    chk("exh_perf", 32'(perfect_lanes), 64);

    // All-zero outputs.
    start_eval();
    cur = base;
    cur.y3 = '0; cur.y2 = '0; cur.y1 = '0; cur.y0 = '0;
    repeat (4) step(1'b1, 1'b0);
    drain();
    chk("zero_score", 32'(score), 200);
    chk("zero_perf", 32'(perfect_lanes), 28);

    // Single flipped bit on one beat.
    start_eval();
    for (int k = 0; k < 4; k++) begin
      cur = base;
      if (k == 2) cur.y1 = cur.y1 ^ 16'h0020;
      step(1'b1, 1'b0);
    end
    drain();
    chk("flip_score", 32'(score), 255);
    chk("flip_perf", 32'(perfect_lanes), 63);

    // Stalls, with a start pulse during ACCUM that must be ignored.
    start_eval();
    cur = base;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    drain();
    chk("stall_score", 32'(score), 256);
    chk("stall_perf", 32'(perfect_lanes), 64);

    // Asynchronous reset mid-evaluation.
    start_eval();
    cur = base;
    repeat (2) step(1'b1, 1'b0);
    chk("pre_rst_score", 32'(score), 64);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_perf", 32'(perfect_lanes), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    #2;
    rst_n   = 1'b1;
    m_ready = 1'b0;
    start_eval();
    cur = base;
    repeat (4) step(1'b1, 1'b0);
    drain();
    chk("post_rst_score", 32'(score), 256);
    chk("post_rst_perf", 32'(perfect_lanes), 64);

    // Random operands with sparse output faults and random valid gaps.
    repeat (4) begin
      start_eval();
      iter = 0;
      while (m_cnt < 4 && iter < 40) begin
        cur.a1 = 16'($urandom); cur.a0 = 16'($urandom);
        cur.b1 = 16'($urandom); cur.b0 = 16'($urandom);
        cur = with_correct_y(cur);
        cur.y3 = cur.y3 ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
        cur.y0 = cur.y0 ^ (16'($urandom) & 16'($urandom));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        iter++;
      end
      chk("rand_xfers", 32'(m_cnt), 4);
      drain();
    end

    // Saturation on the 8-bit accumulator instance.
    good = with_correct_y(base);
    {a1, a0, b1, b0, y3, y2, y1, y0} = good;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2    = 1'b0;
    in_valid2 = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    chk("sat_ready_low", 32'(in_ready2), 0);
    d2 = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done2 === 1'b1) d2++;
    end
    chk("sat_done_pulses", 32'(d2), 1);
    chk("sat_score", 32'(score2), 255);
    chk("sat_perf", 32'(perfect_lanes2), 128);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
